simpleio_timer_bank: RTL and testbench

Parametrised multi-channel timer peripheral for the 8-bit CPU bus, succeeding the single onboard timer in the simple I/O block. It provides CHANNELS independent up-counters of WIDTH bits, each with periodic or one-shot mode, a coherent multi-byte counter snapshot, per-channel interrupt flags with a global enable mask, and one combined irq line to the CPU. Everything runs in the CPU clock domain; there is no separate timer clock.

---
 rtl/simpleio_timer_pkg.sv | 42 ++++
 rtl/simpleio_timer_channel.sv | 79 +++++++
 rtl/simpleio_timer_bank.sv | 69 ++++++
 tb/tb_simpleio_timer_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simpleio_timer_pkg.sv
// rtl/simpleio_timer_pkg.sv - register map, CTRL bit positions and byte helpers for the timer bank
package simpleio_timer_pkg;

   localparam int CHAN_STRIDE = 8;

   localparam logic [5:0] ADDR_STATUS = 6'h00;
   localparam logic [5:0] ADDR_IEN    = 6'h01;

   localparam logic [2:0] OFF_CTRL    = 3'd0;
   localparam logic [2:0] OFF_RELOAD0 = 3'd4;
   localparam logic [2:0] OFF_RELOAD1 = 3'd5;
   localparam logic [2:0] OFF_RELOAD2 = 3'd6;
   localparam logic [2:0] OFF_RELOAD3 = 3'd7;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_FLAG    = 7;

   // Byte index 0 is the most significant byte of the 32-bit view.
   function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] idx);
      case (idx)
         2'd0:    return v[31:24];
         2'd1:    return v[23:16];
         2'd2:    return v[15:8];
         default: return v[7:0];
      endcase
   endfunction

   function automatic logic [31:0] set_byte(input logic [31:0] v, input logic [1:0] idx,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = v;
      case (idx)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         default: r[7:0]   = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/simpleio_timer_channel.sv
// rtl/simpleio_timer_channel.sv - one timer channel: counter, reload, run/oneshot, flag and snapshot shadow
module simpleio_timer_channel
   import simpleio_timer_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr,
   input  logic       rd,
   input  logic       clr,
   input  logic [2:0] offset,
   input  logic [7:0] wdata,
   output logic       flag,
   output logic [7:0] rdata
);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] shadow;
   logic             run;
   logic             oneshot;
   logic             match;
   logic             ctrl_wr;
   logic             reload_wr;
   logic             snap_rd;
   logic [31:0]      reload_ext;
   logic [31:0]      source_ext;
   logic [31:0]      shadow_ext;
   logic [31:0]      reload_new;

   assign match      = run && (count == reload);
   assign ctrl_wr    = wr && (offset == OFF_CTRL);
   assign reload_wr  = wr && offset[2];
   assign snap_rd    = rd && (offset == OFF_RELOAD0);
   assign reload_ext = 32'(reload);
   assign source_ext = run ? 32'(count) : reload_ext;
   assign shadow_ext = 32'(shadow);
   // Bytes above WIDTH fall away in the truncation back to the reload register.
   assign reload_new = set_byte(reload_ext, offset[1:0], wdata);

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         reload  <= '0;
         shadow  <= '0;
         run     <= 1'b0;
         oneshot <= 1'b0;
         flag    <= 1'b0;
      end else begin
         if (run) count <= match ? '0 : count + WIDTH'(1);
         if (match && oneshot) run <= 1'b0;
         if (ctrl_wr) begin
            run     <= wdata[CTRL_RUN];
            oneshot <= wdata[CTRL_ONESHOT];
            if (!run && wdata[CTRL_RUN]) count <= '0;
         end
         if (reload_wr) reload <= reload_new[WIDTH-1:0];
         if (snap_rd) shadow <= source_ext[WIDTH-1:0];
         if (match) flag <= 1'b1;
         else if (clr) flag <= 1'b0;
      end
   end

   // The +4 read returns the freshly captured value; +5..+7 come from the shadow.
   always_comb begin
      rdata = '0;
      case (offset)
         OFF_CTRL: begin
            rdata[CTRL_RUN]     = run;
            rdata[CTRL_ONESHOT] = oneshot;
            rdata[CTRL_FLAG]    = flag;
         end
         OFF_RELOAD0: rdata = byte_of(source_ext, 2'd0);
         default:     if (offset[2]) rdata = byte_of(shadow_ext, offset[1:0]);
      endcase
   end

endmodule

// File: rtl/simpleio_timer_bank.sv
// rtl/simpleio_timer_bank.sv - multi-channel timer peripheral: decode, STATUS/IEN, read data and irq
module simpleio_timer_bank
   import simpleio_timer_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] AD,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   input  logic       rw,
   input  logic       cs,
   output logic       irq
);

   logic [CHANNELS-1:0] flags;
   logic [CHANNELS-1:0] ien;
   logic [CHANNELS-1:0] chan_sel;
   logic [CHANNELS-1:0] clr;
   logic [7:0]          chan_rdata [CHANNELS];
   logic [7:0]          rd_mux;
   logic                wr_en;
   logic                rd_en;

   assign wr_en = cs && !rw;
   assign rd_en = cs && rw;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      assign chan_sel[c] = (AD[5:3] == 3'(c + 1));
      assign clr[c]      = wr_en && (AD == ADDR_STATUS) && DI[c];

      simpleio_timer_channel #(.WIDTH(WIDTH)) u_chan (
         .clk    (clk),
         .rst    (rst),
         .wr     (wr_en && chan_sel[c]),
         .rd     (rd_en && chan_sel[c]),
         .clr    (clr[c]),
         .offset (AD[2:0]),
         .wdata  (DI),
         .flag   (flags[c]),
         .rdata  (chan_rdata[c])
      );
   end

   // Unselected or nonexistent addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      if (AD == ADDR_STATUS) rd_mux = 8'(flags);
      else if (AD == ADDR_IEN) rd_mux = 8'(ien);
      for (int c = 0; c < CHANNELS; c++) begin
         if (chan_sel[c]) rd_mux = chan_rdata[c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         DO  <= '0;
         ien <= '0;
         irq <= 1'b0;
      end else begin
         if (rd_en) DO <= rd_mux;
         if (wr_en && (AD == ADDR_IEN)) ien <= DI[CHANNELS-1:0];
         irq <= |(flags & ien);
      end
   end

endmodule

// File: tb/tb_simpleio_timer_bank.sv
// tb/tb_simpleio_timer_bank.sv - randomized and directed bench with an in-bench timer model
module tb_simpleio_timer_bank;

   localparam int NCH = 4;
   localparam int W   = 24;
   localparam longint MASK = (64'd1 << W) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs, rw;
   logic [5:0] ad;
   logic [7:0] di;
   logic [7:0] dout;
   logic       irq;
   logic       b_cs, b_rw;
   logic [5:0] b_ad;
   logic [7:0] b_di;
   logic [7:0] b_dout;
   logic       b_irq;

   always #5 clk = ~clk;

   simpleio_timer_bank #(.CHANNELS(NCH), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .AD(ad), .DI(di), .DO(dout), .rw(rw), .cs(cs), .irq(irq));

   simpleio_timer_bank #(.CHANNELS(4), .WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .AD(b_ad), .DI(b_di), .DO(b_dout), .rw(b_rw), .cs(b_cs), .irq(b_irq));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 0;

   longint m_count[NCH], m_reload[NCH], m_shadow[NCH];
   bit     m_run[NCH], m_os[NCH], m_flag[NCH];
   bit [7:0] m_ien;
   bit [7:0] exp_do;
   bit       exp_irq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit [7:0] flag_byte();
      bit [7:0] v = 0;
      for (int c = 0; c < NCH; c++) v[c] = m_flag[c];
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_count[c] = 0; m_reload[c] = 0; m_shadow[c] = 0;
         m_run[c] = 0; m_os[c] = 0; m_flag[c] = 0;
      end
      m_ien = 0; exp_do = 0; exp_irq = 0;
   endtask

   // What a read of address a returns given the state before the edge.
   function automatic bit [7:0] model_read(input bit [5:0] a);
      int ch = int'(a) / 8 - 1;
      int off = int'(a) % 8;
      longint v;
      if (a == 0) return flag_byte();
      if (a == 1) return m_ien;
      if (ch < 0 || ch >= NCH || off == 1 || off == 2 || off == 3) return 0;
      if (off == 0) return {m_flag[ch], 5'b0, m_os[ch], m_run[ch]};
      v = (off == 4) ? (m_run[ch] ? m_count[ch] : m_reload[ch]) : m_shadow[ch];
      return 8'((v >> (8 * (7 - off))) & 255);
   endfunction

   task automatic model_step(input bit c_s, input bit r_w, input bit [5:0] a, input bit [7:0] d);
      int ch = int'(a) / 8 - 1;
      int off = int'(a) % 8;
      bit wr = c_s && !r_w;
      bit next_irq = |(flag_byte() & m_ien);
      if (c_s && r_w) begin
         exp_do = model_read(a);
         if (ch >= 0 && ch < NCH && off == 4)
            m_shadow[ch] = m_run[ch] ? m_count[ch] : m_reload[ch];
      end
      for (int c = 0; c < NCH; c++) begin
         bit run0 = m_run[c];
         bit match = run0 && (m_count[c] == m_reload[c]);
         if (run0) m_count[c] = match ? 0 : (m_count[c] + 1) & MASK;
         if (match && m_os[c]) m_run[c] = 0;
         if (wr && a == 0 && d[c]) m_flag[c] = 0;
         if (match) m_flag[c] = 1;
         if (wr && ch == c) begin
            if (off == 0) begin
               m_run[c] = d[0];
               m_os[c]  = d[1];
               if (!run0 && d[0]) m_count[c] = 0;
            end else if (off >= 4) begin
               int sh = 8 * (7 - off);
               m_reload[c] = ((m_reload[c] & ~(longint'(255) << sh)) | (longint'(d) << sh)) & MASK;
            end
         end
      end
      if (wr && a == 1) m_ien = d & 8'h0F;
      exp_irq = next_irq;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("DO", dout, exp_do);
         check("irq", irq, exp_irq);
      end
   end

   task automatic bus(input bit c_s, input bit r_w, input bit [5:0] a, input bit [7:0] d);
      cs = c_s; rw = r_w; ad = a; di = d;
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else model_step(c_s, r_w, a, d);
      #1;
      cs = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(0, 0, 0, 0);
   endtask

   task automatic rd(input bit [5:0] a, output bit [7:0] v);
      bus(1, 1, a, 0);
      v = dout;
   endtask

   task automatic b_bus(input bit r_w, input bit [5:0] a, input bit [7:0] d, output bit [7:0] v);
      b_cs = 1; b_rw = r_w; b_ad = a; b_di = d;
      bus(0, 0, 0, 0);
      b_cs = 0;
      v = b_dout;
   endtask

   initial begin
      bit [7:0] v, b5, b6, b7;
      int s;
      cs = 0; rw = 0; ad = 0; di = 0;
      b_cs = 0; b_rw = 0; b_ad = 0; b_di = 0;
      rst = 1;
      idle(3);
      rst = 0;
      chk_en = 1;

      // Reset state: every address reads zero, irq low.
      check("reset_irq", irq, 0);
      check("reset_do", dout, 0);
      for (int a = 0; a < 64; a++) begin
         rd(6'(a), v);
         check("reset_read", v, 0);
      end

      // Periodic channel 0, RELOAD=4: flag at start+5, irq one clk later.
      bus(1, 0, 6'd15, 8'd4);
      bus(1, 0, 6'd1, 8'h01);
      bus(1, 0, 6'd8, 8'h01);
      idle(5);
      check("period_irq_lag", irq, 0);
      idle(1);
      check("period_irq_rise", irq, 1);
      rd(6'd0, v);
      check("period_status", v, 8'h01);
      bus(1, 0, 6'd0, 8'h01);
      idle(1);
      check("w1c_irq_low", irq, 0);
      idle(2);
      check("period_irq_again", irq, 1);
      bus(1, 0, 6'd8, 8'h00);
      bus(1, 0, 6'd0, 8'h01);

      // One-shot channel 1, RELOAD=2.
      bus(1, 0, 6'd23, 8'd2);
      bus(1, 0, 6'd16, 8'h03);
      idle(3);
      rd(6'd16, v);
      check("oneshot_ctrl", v, 8'h82);
      bus(1, 0, 6'd0, 8'h02);
      idle(10);
      rd(6'd0, v);
      check("oneshot_no_reset", v & 8'h02, 0);

      // Snapshot of free-running channel 2.
      bus(1, 0, 6'd29, 8'hFF);
      bus(1, 0, 6'd30, 8'hFF);
      bus(1, 0, 6'd31, 8'hFF);
      bus(1, 0, 6'd24, 8'h01);
      s = cyc;
      idle($urandom_range(200, 400));
      rd(6'd28, v);
      check("snap_msb", v, 0);
      b5 = 0;
      s = cyc - s - 1;
      rd(6'd29, b5);
      rd(6'd30, b6);
      rd(6'd31, b7);
      check("snap_value", {8'h00, b5, b6, b7}, 32'(s));

      // Match collides with a W1C of the same flag; IEN off.
      bus(1, 0, 6'd1, 8'h00);
      bus(1, 0, 6'd15, 8'd2);
      bus(1, 0, 6'd8, 8'h01);
      idle(2);
      bus(1, 0, 6'd0, 8'h01);
      rd(6'd0, v);
      check("collide_set_wins", v & 8'h01, 1);
      check("collide_irq", irq, 0);
      bus(1, 0, 6'd8, 8'h00);

      // Nonexistent channel 5 block.
      for (int a = 48; a < 56; a++) bus(1, 0, 6'(a), 8'($urandom));
      for (int a = 48; a < 56; a++) begin
         rd(6'(a), v);
         check("ch5_read", v, 0);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int ch = $urandom_range(0, NCH - 1);
         case ($urandom_range(0, 11))
            0, 1, 2, 3: idle(1);
            4:  bus(1, 1, 6'($urandom), 0);
            5:  bus(1, 0, 6'd0, 8'($urandom));
            6:  bus(1, 0, 6'd1, 8'($urandom));
            7:  bus(1, 0, 6'(8 * (ch + 1)), ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3)));
            8:  bus(1, 0, 6'(8 * (ch + 1) + 7), 8'($urandom_range(0, 20)));
            9:  bus(1, 0, 6'(8 * (ch + 1) + $urandom_range(4, 6)), ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00);
            10: for (int k = 4; k < 8; k++) bus(1, 1, 6'(8 * (ch + 1) + k), 0);
            default: bus(1, 0, 6'($urandom), 8'($urandom));
         endcase
      end

      // WIDTH=8 instance: only the +7 byte exists.
      b_bus(0, 6'd12, 8'hAA, v);
      b_bus(0, 6'd13, 8'hBB, v);
      b_bus(0, 6'd14, 8'hCC, v);
      b_bus(0, 6'd15, 8'h05, v);
      b_bus(1, 6'd12, 8'h00, v);
      check("w8_byte4", v, 0);
      b_bus(1, 6'd13, 8'h00, v);
      check("w8_byte5", v, 0);
      b_bus(1, 6'd14, 8'h00, v);
      check("w8_byte6", v, 0);
      b_bus(1, 6'd15, 8'h00, v);
      check("w8_byte7", v, 8'h05);
      b_bus(1, 6'd8, 8'h00, v);
      check("w8_ctrl", v, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
